// File: rtl/fp_div_pkg.sv
// Shared types and constants for the FP mantissa divide path.
package fp_div_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

    localparam int DIV_DEFAULT_BITS = 16;

    // Every quotient bit takes this value on divide-by-zero (all-ones quotient).
    localparam logic DIV_ZERO_QUOT_BIT = 1'b1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract,
// keep the difference if it did not borrow.
import fp_div_pkg::*;

module div_step #(
    parameter int Bits = DIV_DEFAULT_BITS
) (
    input  logic [Bits-1:0] rem,
    input  logic            quot_msb,
    input  logic [Bits-1:0] divisor,
    output logic [Bits-1:0] rem_next,
    output logic            q_bit
);

    logic [Bits:0] trial;

    // The restored remainder is always below the divisor, so the shifted
    // partial fits in Bits+1 bits and the kept remainder fits in Bits bits.
    always_comb begin
        trial    = {rem, quot_msb} - {1'b0, divisor};
        q_bit    = ~trial[Bits];
        rem_next = trial[Bits] ? {rem[Bits-2:0], quot_msb} : trial[Bits-1:0];
    end

endmodule

// File: rtl/div_16bits_seq.sv
// Iterative radix-2 restoring divider with valid/ready on both sides.
// Define DIV_SIGNED_EN for two's-complement operands (truncating quotient).
import fp_div_pkg::*;

module div_16bits_seq #(
    parameter  int Bits = DIV_DEFAULT_BITS,
    localparam int CntW = $clog2(Bits + 1)
) (
    input  logic            iClk,
    input  logic            iRst,
    input  logic            iValid,
    output logic            oReady,
    input  logic [Bits-1:0] iN,
    input  logic [Bits-1:0] iD,
    output logic            oValid,
    input  logic            iReady,
    output logic [Bits-1:0] oQ,
    output logic [Bits-1:0] oR,
    output logic            oDivZero
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid is held, with data stable, until that edge.
    div_state_t      state_q, state_d;
    logic [CntW-1:0] cnt_q;
    logic [Bits-1:0] rem_q, quot_q, div_q;
    logic [Bits-1:0] rem_next, n_op, d_op, q_fin, r_fin;
    logic            q_bit, accept, d_zero, run_last;

    assign accept   = iValid && (state_q == IDLE);
    assign d_zero   = (iD == '0);
    assign run_last = (cnt_q == CntW'(Bits));
    assign oReady   = (state_q == IDLE);
    assign oValid   = (state_q == DONE);

`ifdef DIV_SIGNED_EN
    logic neg_quot_q, neg_rem_q;

    // Magnitudes are unsigned, so |-2^(Bits-1)| is representable.
    assign n_op  = iN[Bits-1] ? (~iN + 1'b1) : iN;
    assign d_op  = iD[Bits-1] ? (~iD + 1'b1) : iD;
    assign q_fin = neg_quot_q ? (~quot_q + 1'b1) : quot_q;
    assign r_fin = neg_rem_q  ? (~rem_q + 1'b1)  : rem_q;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else if (accept) begin
            neg_quot_q <= iN[Bits-1] ^ iD[Bits-1];
            neg_rem_q  <= iN[Bits-1];
        end
    end
`else
    assign n_op  = iN;
    assign d_op  = iD;
    assign q_fin = quot_q;
    assign r_fin = rem_q;
`endif

    div_step #(.Bits(Bits)) u_step (
        .rem      (rem_q),
        .quot_msb (quot_q[Bits-1]),
        .divisor  (div_q),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = d_zero ? DONE : RUN;
            RUN:     if (run_last) state_d = DONE;
            DONE:    if (iReady) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            cnt_q    <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            div_q    <= '0;
            oQ       <= '0;
            oR       <= '0;
            oDivZero <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && d_zero) begin
                        oQ       <= {Bits{DIV_ZERO_QUOT_BIT}};
                        oR       <= iN;
                        oDivZero <= 1'b1;
                    end else if (accept) begin
                        quot_q <= n_op;
                        div_q  <= d_op;
                        rem_q  <= '0;
                        cnt_q  <= '0;
                    end
                end
                RUN: begin
                    // The extra cycle after the last iteration registers the results.
                    if (run_last) begin
                        oQ       <= q_fin;
                        oR       <= r_fin;
                        oDivZero <= 1'b0;
                    end else begin
                        rem_q  <= rem_next;
                        quot_q <= {quot_q[Bits-2:0], q_bit};
                        cnt_q  <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
